// File: rtl/csa_mult_seq.sv
// Sequential multiplier: partial products folded into a carry-save pair a few
// rows per cycle, then resolved with a single carry-propagate add.
module csa_mult_seq #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PP_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned N  = WIDTH / PP_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic            sgn_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   sum_q, carry_q;
  logic [PW-1:0]   sum_d, carry_d;
  logic            last_c;

  assign last_c = (cnt_q == CW'(N - 1));

  // State register plus registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = ACCUM;
      ACCUM:   if (last_c)    state_d = RESOLVE;
      RESOLVE:                state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // 3:2 compressor chain; the signed top row is inverted and its +1 rides in
  // the free LSB of the shifted carry vector.
  always_comb begin
    logic [PW-1:0] row;
    logic [PW-1:0] maj;
    logic          neg;
    sum_d   = sum_q;
    carry_d = carry_q;
    for (int k = 0; k < int'(PP_PER_CYCLE); k++) begin
      row = mplier_q[k] ? (mcand_q << k) : '0;
      neg = sgn_q && last_c && (k == int'(PP_PER_CYCLE) - 1);
      if (neg) row = ~row;
      maj     = (sum_d & carry_d) | (sum_d & row) | (carry_d & row);
      sum_d   = sum_d ^ carry_d ^ row;
      carry_d = {maj[PW-2:0], neg};
    end
  end

  // Operand, accumulator and product registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      p        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
            mplier_q <= b;
            sgn_q    <= signed_mode;
            cnt_q    <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
          end
        end
        ACCUM: begin
          sum_q    <= sum_d;
          carry_q  <= carry_d;
          mcand_q  <= mcand_q << PP_PER_CYCLE;
          mplier_q <= mplier_q >> PP_PER_CYCLE;
          cnt_q    <= cnt_q + CW'(1);
        end
        RESOLVE: p <= sum_q + carry_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mult_seq.sv
// Bench for csa_mult_seq: arithmetic reference with a latency/handshake model,
// checked every cycle, plus directed literal cases and reset abort.
module tb_csa_mult_seq;

  localparam int W  = 8;
  localparam int PP = 2;
  localparam int N  = W / PP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] p;
  logic          busy;

  int tests = 0;
  int fails = 0;

  csa_mult_seq #(.WIDTH(W), .PP_PER_CYCLE(PP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    logic signed [2*W-1:0] sx, sy;
    if (s) begin
      sx = $signed({{W{x[W-1]}}, x});
      sy = $signed({{W{y[W-1]}}, y});
      return (2*W)'(sx * sy);
    end
    return (2*W)'({{W{1'b0}}, x} * {{W{1'b0}}, y});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: product due N+1 edges after acceptance, held until taken
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;
  logic [2*W-1:0] m_p = '0;
  logic [2*W-1:0] m_exp = '0;
  int            m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_p = '0; m_cnt = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_cnt  = N + 1;
        m_exp  = ref_prod(a, b, signed_mode);
      end
    end else if (!m_valid) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_p     = m_exp;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
    check("cyc_busy", 32'(busy), 32'(m_busy));
    check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    check("cyc_p", 32'(p), 32'(m_p));
  end

  task automatic xact(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                      input logic [2*W-1:0] lit, input int hold, input logic pin);
    int lat;
    if (pin) check("model_literal", 32'(ref_prod(ta, tb2, ts)), 32'(lit));
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("in_ready_before", 32'(in_ready), 32'd1);
    a = ta; b = tb2; signed_mode = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(N + 1));
    check("product", 32'(p), 32'(lit));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      signed_mode = 1'($urandom);
      @(posedge clk); #1;
      check("hold_p", 32'(p), 32'(lit));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("taken_valid", 32'(out_valid), 32'd0);
    check("taken_in_ready", 32'(in_ready), 32'd1);
    check("p_retained", 32'(p), 32'(lit));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    xact(8'd15,  8'd15,  1'b0, 16'h00E1, 0,  1'b1);
    xact(8'hFF,  8'hFF,  1'b0, 16'hFE01, 2,  1'b1);
    xact(8'h00,  8'hFF,  1'b0, 16'h0000, 0,  1'b1);
    xact(8'h80,  8'h80,  1'b1, 16'h4000, 0,  1'b1);
    xact(8'hFF,  8'h01,  1'b1, 16'hFFFF, 1,  1'b1);
    xact(8'h7F,  8'h80,  1'b1, 16'hC080, 10, 1'b1);
    xact(8'hFF,  8'hFF,  1'b1, 16'h0001, 0,  1'b1);
    xact(8'h80,  8'h7F,  1'b0, 16'h3F80, 0,  1'b1);
    xact(8'hFB,  8'h06,  1'b1, 16'hFFE2, 0,  1'b1);

    // Abort during the second accumulate cycle
    a = 8'h55; b = 8'h33; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_product", 32'(out_valid), 32'd0);
    end
    xact(8'd3, 8'd5, 1'b0, 16'd15, 0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      xact(ra, rb, rs, ref_prod(ra, rb, rs), int'($urandom_range(0, 3)), 1'b0);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
